// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared definitions for the acquisition sample buffer:
//   - default sample width and depth
//   - control FSM state encoding
// -----------------------------------------------------------------------------
package acq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILL    = 2'b01,
    ST_READOUT = 2'b10
  } state_t;

endpackage : acq_pkg

// File: rtl/acq_ram.sv
// -----------------------------------------------------------------------------
// acq_ram
// DEPTH x DATA_W sample RAM with one write port and a registered read port.
// Ports:
//   new_clk  in   clock, rising edge
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr    in   read address, sampled every edge
//   rdata    out  registered read data (mem[raddr] from the previous edge)
// -----------------------------------------------------------------------------
module acq_ram
  import acq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              new_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents are only
  // ever read back after the capture that wrote them.
  always_ff @(posedge new_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule : acq_ram

// File: rtl/acq_buffer.sv
// -----------------------------------------------------------------------------
// acq_buffer
// Sample store fed by the acquisition control FSM. Captures samples into a RAM
// on en/inc/write strobes, reports full/count, then plays the capture out on a
// request/valid read port after done and re-arms.
//
// Build option: define ACQ_BUF_OVF_EN to enable the sticky overflow flag;
// otherwise ovf is tied low.
//
// Ports:
//   new_clk   in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   data_in   in   sample bus
//   en        in   latch data_in into the hold register
//   inc       in   advance write address (paired with en)
//   write     in   commit hold register to mem[wr_addr]
//   done      in   end-of-capture pulse
//   full      out  all DEPTH locations written
//   count     out  number of locations written, 0..DEPTH
//   rd_req    in   read request, honoured in READOUT only
//   rd_data   out  read sample, held until the next read
//   rd_valid  out  one-cycle qualifier for rd_data
//   rd_last   out  final sample marker
//   busy      out  high in FILL or READOUT
//   ovf       out  sticky overflow flag
// -----------------------------------------------------------------------------
module acq_buffer
  import acq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              new_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en,
  input  logic              inc,
  input  logic              write,
  input  logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              ovf
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_n;
  logic [ADDR_W-1:0]   rd_addr, rd_addr_n;
  logic [DATA_W-1:0]   hold, hold_n;
  logic                written_cur, written_cur_n;
  logic                full_n, rd_valid_n, rd_last_n;
  logic [CNT_W-1:0]    count_n;
  logic [DATA_W-1:0]   ram_rdata, rd_hold;
  logic                ram_we;
  logic                last_rd;
  logic                ovf_set, ovf_clr;

  assign ram_we  = (state == ST_FILL) && write;
  assign last_rd = (CNT_W'(rd_addr) == (count - CNT_W'(1)));
  assign busy    = (state != ST_IDLE);

  acq_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .new_clk (new_clk),
    .we      (ram_we),
    .waddr   (wr_addr),
    .wdata   (hold),
    .raddr   (rd_addr),
    .rdata   (ram_rdata)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n       = state;
    wr_addr_n     = wr_addr;
    rd_addr_n     = rd_addr;
    hold_n        = hold;
    written_cur_n = written_cur;
    full_n        = full;
    rd_valid_n    = 1'b0;
    rd_last_n     = 1'b0;
    ovf_set       = 1'b0;
    ovf_clr       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (en) begin
          hold_n        = data_in;
          wr_addr_n     = '0;
          written_cur_n = 1'b0;
          ovf_clr       = 1'b1;
          state_n       = ST_FILL;
        end
      end

      ST_FILL: begin
        // The RAM write uses the current hold/address; an en&inc in the same
        // cycle only affects the following location.
        if (write) begin
          written_cur_n = 1'b1;
          if (wr_addr == LAST_ADDR) full_n = 1'b1;
        end
        if (en && inc) begin
          if (wr_addr != LAST_ADDR) begin
            wr_addr_n     = wr_addr + ADDR_W'(1);
            hold_n        = data_in;
            written_cur_n = 1'b0;
          end else begin
            ovf_set = 1'b1;  // saturated: address, hold and written flag frozen
          end
        end else if (en) begin
          hold_n = data_in;
        end
        if (done) begin
          rd_addr_n = '0;
          state_n   = (count == '0) ? ST_IDLE : ST_READOUT;
        end
      end

      ST_READOUT: begin
        if (rd_req) begin
          rd_valid_n = 1'b1;
          rd_last_n  = last_rd;
          rd_addr_n  = rd_addr + ADDR_W'(1);
          if (last_rd) begin
            state_n       = ST_IDLE;
            full_n        = 1'b0;
            wr_addr_n     = '0;
            written_cur_n = 1'b0;
            rd_addr_n     = '0;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    count_n = CNT_W'(wr_addr_n) + CNT_W'(written_cur_n);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge new_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      hold        <= '0;
      written_cur <= 1'b0;
      full        <= 1'b0;
      count       <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_hold     <= '0;
    end else begin
      state       <= state_n;
      wr_addr     <= wr_addr_n;
      rd_addr     <= rd_addr_n;
      hold        <= hold_n;
      written_cur <= written_cur_n;
      full        <= full_n;
      count       <= count_n;
      rd_valid    <= rd_valid_n;
      rd_last     <= rd_last_n;
      if (rd_valid) rd_hold <= ram_rdata;
    end
  end

  // The RAM output register follows rd_addr every cycle, so the last
  // presented sample is kept in rd_hold once rd_valid drops.
  assign rd_data = rd_valid ? ram_rdata : rd_hold;

`ifdef ACQ_BUF_OVF_EN
  logic ovf_q;
  always_ff @(posedge new_clk) begin
    if (reset)        ovf_q <= 1'b0;
    else if (ovf_clr) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_set ^ ovf_clr;
  assign ovf        = 1'b0;
`endif

endmodule : acq_buffer

// File: tb/tb_acq_buffer.sv
// -----------------------------------------------------------------------------
// tb_acq_buffer
// Self-checking bench for acq_buffer: a behavioural sample-store model is
// compared against the DUT outputs every cycle, and directed sequences add
// hand-computed expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acq_buffer;

  localparam int DEPTH = 16;

`ifdef ACQ_BUF_OVF_EN
  localparam bit OVF_BUILD = 1'b1;
`else
  localparam bit OVF_BUILD = 1'b0;
`endif

  logic       new_clk = 1'b0;
  logic       reset, en, inc, write, done, rd_req;
  logic [7:0] data_in;
  logic       full, rd_valid, rd_last, busy, ovf;
  logic [4:0] count;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 new_clk = ~new_clk;

  acq_buffer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .new_clk  (new_clk),
    .reset    (reset),
    .data_in  (data_in),
    .en       (en),
    .inc      (inc),
    .write    (write),
    .done     (done),
    .full     (full),
    .count    (count),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .busy     (busy),
    .ovf      (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FILL, M_READ} mphase_t;
  mphase_t    m_phase;
  int         m_addr, m_rd, m_cnt;
  bit         m_wr, m_full, m_ovf, m_rd_valid, m_rd_last;
  logic [7:0] m_hold, m_rd_data;
  logic [7:0] m_mem [DEPTH];

  always @(posedge new_clk) begin
    m_rd_valid = 1'b0;
    m_rd_last  = 1'b0;
    m_cnt      = m_addr + int'(m_wr);
    if (reset) begin
      m_phase = M_IDLE; m_addr = 0; m_wr = 0; m_hold = 8'h00;
      m_full = 0; m_ovf = 0; m_rd = 0; m_rd_data = 8'h00;
    end else begin
      case (m_phase)
        M_IDLE: if (en) begin
          m_hold = data_in; m_addr = 0; m_wr = 0; m_ovf = 0; m_phase = M_FILL;
        end
        M_FILL: begin
          if (write) begin
            m_mem[m_addr] = m_hold;
            m_wr = 1;
            if (m_addr == DEPTH - 1) m_full = 1;
          end
          if (en && inc) begin
            if (m_addr < DEPTH - 1) begin
              m_addr++; m_hold = data_in; m_wr = 0;
            end else if (OVF_BUILD) begin
              m_ovf = 1;
            end
          end else if (en) begin
            m_hold = data_in;
          end
          if (done) begin
            m_rd = 0;
            m_phase = (m_cnt == 0) ? M_IDLE : M_READ;
          end
        end
        M_READ: if (rd_req) begin
          m_rd_data  = m_mem[m_rd];
          m_rd_valid = 1;
          m_rd_last  = (m_rd == m_cnt - 1);
          if (m_rd_last) begin
            m_phase = M_IDLE; m_full = 0; m_addr = 0; m_wr = 0; m_rd = 0;
          end else begin
            m_rd++;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge new_clk) begin
    if (chk_en) begin
      check("count",    32'(count),    32'(m_addr + int'(m_wr)));
      check("full",     32'(full),     32'(m_full));
      check("busy",     32'(busy),     32'(m_phase != M_IDLE));
      check("ovf",      32'(ovf),      32'(m_ovf));
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      check("rd_last",  32'(rd_last),  32'(m_rd_last));
      check("rd_data",  32'(rd_data),  32'(m_rd_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge new_clk);
    #1;
  endtask

  task automatic clr();
    en = 0; inc = 0; write = 0; done = 0; rd_req = 0;
  endtask

  task automatic capture(input logic [7:0] d, input bit with_inc, input int nw);
    en = 1; inc = with_inc; data_in = d;
    tick();
    en = 0; inc = 0;
    repeat (nw) begin
      write = 1;
      tick();
    end
    write = 0;
  endtask

  initial begin
    clr();
    data_in = 8'h00;
    reset   = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    check("rst_count", 32'(count), 0);
    check("rst_full",  32'(full), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_valid", 32'(rd_valid), 0);

    // Single sample
    capture(8'hA5, 1'b0, 3);
    check("single_count", 32'(count), 1);
    check("single_full",  32'(full), 0);
    done = 1; tick(); done = 0;
    check("single_readout_busy", 32'(busy), 1);
    rd_req = 1; tick(); rd_req = 0;
    check("single_rd_data",  32'(rd_data), 32'h A5);
    check("single_rd_valid", 32'(rd_valid), 1);
    check("single_rd_last",  32'(rd_last), 1);
    check("single_count0",   32'(count), 0);
    check("single_idle",     32'(busy), 0);
    tick();
    check("single_valid_drop", 32'(rd_valid), 0);
    check("single_data_hold",  32'(rd_data), 32'h A5);

    // rd_req in IDLE is ignored
    rd_req = 1; tick(); rd_req = 0;
    check("idle_rdreq_valid", 32'(rd_valid), 0);

    // done with nothing written goes straight back to IDLE
    en = 1; data_in = 8'h77; tick(); en = 0;
    done = 1; tick(); done = 0;
    check("empty_done_idle", 32'(busy), 0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      en = 1; inc = (i != 0); data_in = 8'(8'h10 + i);
      tick();
      en = 0; inc = 0;
      if (i == 15) begin
        check("pre_full", 32'(full), 0);
        check("cnt15",    32'(count), 15);
      end
      write = 1;
      tick();
      if (i == 15) begin
        check("full_rise", 32'(full), 1);
        check("cnt16",     32'(count), 16);
      end
      tick();
      write = 0;
    end

    // Saturation: 17th en&inc while full, then a write of the frozen hold
    en = 1; inc = 1; data_in = 8'hFF; tick(); en = 0; inc = 0;
    check("sat_count", 32'(count), 16);
    check("sat_full",  32'(full), 1);
    check("sat_ovf",   32'(ovf), 32'(OVF_BUILD));
    write = 1; tick(); write = 0;

    // Enter READOUT, then strobes that must be ignored
    done = 1; tick(); done = 0;
    en = 1; inc = 1; data_in = 8'hEE; tick(); clr();
    write = 1; tick(); write = 0;
    done = 1; tick(); done = 0;
    check("ro_busy",  32'(busy), 1);
    check("ro_count", 32'(count), 16);

    // Streaming readout
    rd_req = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("stream_data",  32'(rd_data), 32'(8'h10 + i));
      check("stream_valid", 32'(rd_valid), 1);
      check("stream_last",  32'(rd_last), 32'(i == 15));
    end
    rd_req = 0;
    check("post_stream_busy",  32'(busy), 0);
    check("post_stream_full",  32'(full), 0);
    check("post_stream_count", 32'(count), 0);
    tick();

    // Reset mid-FILL
    for (int i = 0; i < 5; i++) capture(8'(8'h30 + i), (i != 0), 1);
    check("pre_rst_count", 32'(count), 5);
    reset = 1; tick(); reset = 0;
    check("midrst_count", 32'(count), 0);
    check("midrst_full",  32'(full), 0);
    check("midrst_busy",  32'(busy), 0);
    check("midrst_ovf",   32'(ovf), 0);

    // Fresh capture starts at address 0
    capture(8'h55, 1'b0, 1);
    check("fresh_count", 32'(count), 1);
    done = 1; tick(); done = 0;
    rd_req = 1; tick(); rd_req = 0;
    check("fresh_rd_data", 32'(rd_data), 32'h55);
    check("fresh_rd_last", 32'(rd_last), 1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_acq_buffer

// File: doc/acq_buffer.md
Name: acq_buffer

Overview:
Sample store directly downstream of the acquisition control FSM. It consumes that FSM's en/inc/write/done strobes and an 8-bit sample bus, writes samples sequentially into an internal RAM, and returns the full flag that ends a capture. After done, it plays captured samples out on a simple request/valid read port, then re-arms for the next capture.

Parameters:
- DATA_W, 8, sample width in bits.
- DEPTH, 16, number of sample locations; power of two, at least 2.
- ADDR_W, 4, equals log2(DEPTH).

Ports:
- new_clk  in  1  acquisition clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  sample bus from the ADC/input stage.
- en  in  1  capture strobe: latch data_in into the hold register.
- inc  in  1  advance the write address; always paired with en.
- write  in  1  level; commit the hold register to mem[wr_addr].
- done  in  1  one-cycle end-of-capture pulse.
- full  out  1  registered; all DEPTH locations written.
- count  out  ADDR_W+1  number of distinct locations written, 0..DEPTH.
- rd_req  in  1  read request, honoured only in READOUT.
- rd_data  out  DATA_W  read sample.
- rd_valid  out  1  one-cycle qualifier for rd_data.
- rd_last  out  1  asserted with rd_valid on the final sample.
- busy  out  1  high in FILL or READOUT.
- ovf  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset, synchronous on new_clk: state=IDLE, wr_addr=0, rd_addr=0, hold=0, written_cur=0. All outputs 0: full, count, rd_data, rd_valid, rd_last, busy, ovf. RAM contents are not reset.
- count = wr_addr + written_cur. It is registered and zero-extended to ADDR_W+1 bits.
- IDLE:
  - en -> hold<=data_in, wr_addr<=0, written_cur<=0, go to FILL.
  - inc, write and done are ignored.
- FILL:
  - write -> mem[wr_addr]<=hold, written_cur<=1. Repeated writes of the same value are harmless.
  - en&inc with wr_addr<DEPTH-1 -> wr_addr<=wr_addr+1, hold<=data_in, written_cur<=0.
  - en&inc with wr_addr==DEPTH-1 -> saturate: wr_addr, hold and written_cur are unchanged. The address never wraps.
  - en without inc in FILL -> hold<=data_in only.
  - full<=1 on the edge after a write at wr_addr==DEPTH-1. Latency: write cycle N gives full high at N+1.
  - Same cycle write and en&inc: the write uses the old hold and old address; the increment takes effect after.
  - done -> go to READOUT with rd_addr=0. If count==0, go straight to IDLE instead.
- READOUT:
  - rd_req -> rd_data<=mem[rd_addr] and rd_valid<=1 on the next edge. rd_last=1 when rd_addr==count-1.
  - rd_addr then increments.
  - After the edge that presents the last sample: state=IDLE, full<=0, wr_addr<=0, count<=0, rd_addr<=0.
  - rd_req held continuously streams one sample per cycle.
  - en, inc, write and done are ignored in this state.
- rd_valid and rd_last are single-cycle. rd_data holds its value until the next read.
- rd_req outside READOUT is ignored; rd_valid stays 0.
- Reset mid-FILL or mid-READOUT returns to the reset values on the next edge. Partial data is discarded.

Optional Feature:
- Macro ACQ_BUF_OVF_EN.
- Defined: ovf sets on en&inc while full==1 or wr_addr==DEPTH-1 in FILL. It stays set until reset or until the next IDLE->FILL transition.
- Undefined: no overflow logic; ovf is tied to 0. Saturation behaviour is identical in both builds.

Decomposition:
- Package acq_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_FILL=2'b01, ST_READOUT=2'b10;
  - DATA_W and DEPTH defaults.
- Sub-module acq_ram: single-port-write / registered-read RAM, DEPTH x DATA_W. It has ports new_clk, we, waddr, wdata, raddr, rdata, and no reset.
- acq_buffer instantiates acq_ram and holds the control FSM and pointers.

Test Plan:
- Single sample:
  - Stimulus: reset; en with data_in=8'hA5; write for 3 cycles; done; rd_req for 1 cycle.
  - Response: count=1, full=0; rd_data=8'hA5 with rd_valid=1 and rd_last=1; then IDLE and count=0.
- Fill to full:
  - Stimulus: 16 captures of data 0x10..0x1F; each capture is en (plus inc after the first) followed by 2 write cycles.
  - Response: full rises the cycle after the write at address 15; count=16.
- Streaming readout:
  - Stimulus: after the fill to full, done, then rd_req held for 16 cycles.
  - Response: rd_data sequence 0x10..0x1F; rd_last only with 0x1F; then busy=0, full=0.
- Saturation and overflow:
  - Stimulus: a 17th en&inc while full, with data_in=8'hFF.
  - Response: wr_addr stays 15 and mem[15] stays 0x1F. ovf=1 with ACQ_BUF_OVF_EN defined; ovf=0 with it undefined.
- Ignore rules:
  - Stimulus: pulse rd_req in IDLE; pulse en, write and done during READOUT.
  - Response: no rd_valid in IDLE; readout contents unchanged.
- Reset mid-operation:
  - Stimulus: assert reset after 5 samples in FILL.
  - Response: next edge gives count=0, full=0, busy=0, ovf=0; a fresh capture then starts at address 0.
